// File: rtl/from_dec_pkg.sv
// Shared definitions for the five-digit ASCII decimal to binary converter.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package from_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [7:0]  ASCII_ZERO  = 8'h30;
   localparam logic [7:0]  ASCII_SPACE = 8'h20;
   localparam int          NUM_DIGITS  = 5;
   localparam logic [16:0] MAX_VALUE   = 17'd65535;

   // Step counter value at which the last character is consumed.
   localparam logic [2:0]  LAST_STEP   = 3'(NUM_DIGITS - 1);

endpackage

// File: rtl/from_dec_if.sv
// Request/result bundle of the ASCII decimal converter.
// Latency: n/a (wires only).
// Backpressure: none; start is simply ignored while a conversion is running.
// Ports: start + five ASCII chars (MSB first) in; busy, done, value,
//        overflow, bad_char out of the converter.
interface from_dec_if;
   logic        start;
   logic [7:0]  ten_thousands;
   logic [7:0]  thousands;
   logic [7:0]  hundreds;
   logic [7:0]  tens;
   logic [7:0]  units;
   logic        busy;
   logic        done;
   logic [15:0] value;
   logic        overflow;
   logic        bad_char;

   modport master (
      output start, ten_thousands, thousands, hundreds, tens, units,
      input  busy, done, value, overflow, bad_char
   );

   modport slave (
      input  start, ten_thousands, thousands, hundreds, tens, units,
      output busy, done, value, overflow, bad_char
   );
endinterface

// File: rtl/from_dec_char.sv
// Classifies one ASCII character as digit, space or illegal.
// Latency: combinational.
// Backpressure: none.
// Ports: ch in; is_digit, is_space, digit_val (0 when not a digit) out.
module from_dec_char
   import from_dec_pkg::*;
(
   input  logic [7:0] ch,
   output logic       is_digit,
   output logic       is_space,
   output logic [3:0] digit_val
);

   logic [7:0] offset;

   // Characters below '0' wrap to large values, so one compare covers both bounds.
   assign offset    = ch - ASCII_ZERO;
   assign is_digit  = (offset < 8'd10);
   assign is_space  = (ch == ASCII_SPACE);
   assign digit_val = is_digit ? offset[3:0] : 4'd0;

endmodule

// File: rtl/from_dec.sv
// Converts five ASCII decimal characters to a 16-bit value with overflow/illegal flags.
// Latency: done pulses 6 cycles after the accepting edge; one conversion per 7 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
// Ports: clk, rst_i (sync, active high), bus (from_dec_if.slave).
module from_dec
   import from_dec_pkg::*;
#(
   parameter int ALLOW_SPACE = 1
)
(
   input  logic    clk,
   input  logic    rst_i,
   from_dec_if.slave bus
);

   state_t      state_q,  state_d;
   logic [39:0] shreg_q,  shreg_d;
   logic [16:0] acc_q,    acc_d;
   logic [2:0]  step_q,   step_d;
   logic        bad_q,    bad_d;
   logic        seen_q,   seen_d;   // a non-space character has been consumed
   logic        busy_q,   busy_d;
   logic        done_q,   done_d;
   logic [15:0] value_q,  value_d;
   logic        ovf_q,    ovf_d;
   logic        badc_q,   badc_d;

   logic        is_digit;
   logic        is_space;
   logic [3:0]  digit_val;
   logic [16:0] acc_next;
   logic        leading_blank;

   from_dec_char u_char (
      .ch        (shreg_q[39:32]),
      .is_digit  (is_digit),
      .is_space  (is_space),
      .digit_val (digit_val)
   );

   // acc*10 + digit; at most 9999*10+9, so 17 bits never wrap.
   assign acc_next      = (acc_q << 3) + (acc_q << 1) + {13'd0, digit_val};
   assign leading_blank = is_space && (ALLOW_SPACE != 0) && !seen_q;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      acc_d   = acc_q;
      step_d  = step_q;
      bad_d   = bad_q;
      seen_d  = seen_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      value_d = value_q;
      ovf_d   = ovf_q;
      badc_d  = badc_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               shreg_d = {bus.ten_thousands, bus.thousands, bus.hundreds,
                          bus.tens, bus.units};
               acc_d   = '0;
               step_d  = '0;
               bad_d   = 1'b0;
               seen_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = ST_ACCUM;
            end
         end

         ST_ACCUM: begin
            if (is_digit) begin
               acc_d = acc_next;
            end else if (!leading_blank) begin
               bad_d = 1'b1;
            end
            seen_d  = seen_q | ~is_space;
            shreg_d = {shreg_q[31:0], 8'h00};
            step_d  = step_q + 3'd1;
            if (step_q == LAST_STEP) begin
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
            if (bad_q) begin
               value_d = 16'h0000;
               ovf_d   = 1'b0;
               badc_d  = 1'b1;
            end else if (acc_q > MAX_VALUE) begin
               value_d = 16'hFFFF;
               ovf_d   = 1'b1;
               badc_d  = 1'b0;
            end else begin
               value_d = acc_q[15:0];
               ovf_d   = 1'b0;
               badc_d  = 1'b0;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         shreg_q <= '0;
         acc_q   <= '0;
         step_q  <= '0;
         bad_q   <= 1'b0;
         seen_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         value_q <= '0;
         ovf_q   <= 1'b0;
         badc_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         acc_q   <= acc_d;
         step_q  <= step_d;
         bad_q   <= bad_d;
         seen_q  <= seen_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         value_q <= value_d;
         ovf_q   <= ovf_d;
         badc_q  <= badc_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.value    = value_q;
   assign bus.overflow = ovf_q;
   assign bus.bad_char = badc_q;

endmodule

// File: tb/tb_from_dec.sv
// Scoreboard bench for from_dec: expected results are queued when a request is
// driven and compared (value, flags, latency) when done pulses.
module tb_from_dec;

   logic clk   = 1'b0;
   logic rst_i = 1'b1;

   always #5 clk = ~clk;

   from_dec_if bus ();

   from_dec #(.ALLOW_SPACE(1)) dut (
      .clk   (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   typedef struct {
      string       tag;
      logic [15:0] value;
      logic        ovf;
      logic        bad;
      int          done_cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc      = 0;
   int   checks   = 0;
   int   failures = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic set_chars(input logic [39:0] s);
      bus.ten_thousands = s[39:32];
      bus.thousands     = s[31:24];
      bus.hundreds      = s[23:16];
      bus.tens          = s[15:8];
      bus.units         = s[7:0];
   endtask

   task automatic push_exp(input string tag, input logic [15:0] v, input logic o,
                           input logic b, input int accept_cyc);
      exp_t e;
      e.tag      = tag;
      e.value    = v;
      e.ovf      = o;
      e.bad      = b;
      e.done_cyc = accept_cyc + 6;
      sb.push_back(e);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (sb.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check_eq("drain", 32'(sb.size()), 32'd0);
   endtask

   // One request, start held for a single cycle; inputs are scrambled right
   // after acceptance to prove they were captured at the accepting edge.
   task automatic run_conv(input string tag, input logic [39:0] s, input logic [15:0] v,
                           input logic o, input logic b);
      @(negedge clk);
      set_chars(s);
      bus.start = 1'b1;
      push_exp(tag, v, o, b, cyc + 1);
      @(negedge clk);
      bus.start = 1'b0;
      set_chars("9x9x9");
      check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
      wait_drain(12);
   endtask

   // Result monitor.
   always @(negedge clk) begin
      exp_t e;
      if (bus.done) begin
         check_eq("done_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq({e.tag, "_value"},    32'(bus.value),    32'(e.value));
            check_eq({e.tag, "_overflow"}, 32'(bus.overflow), 32'(e.ovf));
            check_eq({e.tag, "_bad_char"}, 32'(bus.bad_char), 32'(e.bad));
            check_eq({e.tag, "_latency"},  32'(cyc),          32'(e.done_cyc));
            check_eq({e.tag, "_busy_low"}, 32'(bus.busy),     32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      bus.start = 1'b0;
      set_chars("00000");

      repeat (3) @(negedge clk);
      check_eq("rst_busy",     32'(bus.busy),     32'd0);
      check_eq("rst_done",     32'(bus.done),     32'd0);
      check_eq("rst_value",    32'(bus.value),    32'd0);
      check_eq("rst_overflow", 32'(bus.overflow), 32'd0);
      check_eq("rst_bad_char", 32'(bus.bad_char), 32'd0);
      rst_i = 1'b0;

      run_conv("c65535", "65535", 16'hFFFF, 1'b0, 1'b0);
      run_conv("c65536", "65536", 16'hFFFF, 1'b1, 1'b0);
      run_conv("c99999", "99999", 16'hFFFF, 1'b1, 1'b0);
      run_conv("c__042", "  042", 16'd42,   1'b0, 1'b0);
      run_conv("c4_2__", "4 2  ", 16'd0,    1'b0, 1'b1);
      run_conv("c12a45", "12a45", 16'd0,    1'b0, 1'b1);
      run_conv("cblank", "     ", 16'd0,    1'b0, 1'b0);

      // start held high for 10 edges: accepted at the first edge and again 7 later.
      @(negedge clk);
      set_chars("00000");
      bus.start = 1'b1;
      n0 = cyc;
      push_exp("hold0", 16'd0, 1'b0, 1'b0, n0 + 1);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) begin
            set_chars("01234");
            push_exp("hold1", 16'd1234, 1'b0, 1'b0, n0 + 8);
         end
         if (k == 8)  set_chars("99999");
         if (k == 10) bus.start = 1'b0;
      end
      wait_drain(12);
      repeat (8) @(negedge clk);

      // start pulsed during ACCUM and during DONE: both must be dropped.
      @(negedge clk);
      set_chars("00321");
      bus.start = 1'b1;
      n0 = cyc;
      push_exp("busy", 16'd321, 1'b0, 1'b0, n0 + 1);
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 1) set_chars("09999");
         bus.start = (k == 2 || k == 6);
      end
      wait_drain(12);
      repeat (8) @(negedge clk);

      // Reset during the third ACCUM cycle discards the conversion.
      @(negedge clk);
      set_chars("54321");
      bus.start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         rst_i     = (k == 3);
      end
      check_eq("mid_rst_busy",     32'(bus.busy),     32'd0);
      check_eq("mid_rst_done",     32'(bus.done),     32'd0);
      check_eq("mid_rst_value",    32'(bus.value),    32'd0);
      check_eq("mid_rst_overflow", 32'(bus.overflow), 32'd0);
      check_eq("mid_rst_bad_char", 32'(bus.bad_char), 32'd0);
      repeat (10) @(negedge clk);

      run_conv("c00007", "00007", 16'd7, 1'b0, 1'b0);
      repeat (10) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/from_dec.md
FROM_DEC -- requirements
Module: from_dec

Interface
REQ-001 SHALL have parameter ALLOW_SPACE, default 1; when 1, ASCII space (8'h20) before the first non-space character is accepted as a leading blank worth 0.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: conversion request, sampled only in IDLE.
REQ-005 SHALL have ports ten_thousands, thousands, hundreds, tens and units, each input, 8 bits: ASCII digits, most significant first.
REQ-006 SHALL have port busy, output, 1 bit: high from the accepting edge until the cycle in which done is high.
REQ-007 SHALL have port done, output, 1 bit: one-cycle pulse marking a new result.
REQ-008 SHALL have port value, output, 16 bits: binary result.
REQ-009 SHALL have port overflow, output, 1 bit: parsed number > 65535.
REQ-010 SHALL have port bad_char, output, 1 bit: an illegal character was present.

Function
REQ-011 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-012 In IDLE with start=1 at edge t, SHALL capture all five inputs into a 40-bit shift register, clear the 17-bit accumulator, step counter and flags, enter ACCUM and raise busy.
REQ-013 Each ACCUM edge SHALL consume the MSB character c: if '0'..'9', acc <= (acc<<3)+(acc<<1)+(c-8'h30); then shift the register left 8 bits and increment the step counter.
REQ-014 A space SHALL add 0 to the accumulator only when ALLOW_SPACE=1 and no non-space character has been consumed yet; any other non-digit character, including a space after a digit, SHALL set the sticky internal bad flag and add 0.
REQ-015 After the 5th consume (step counter = 4), SHALL enter DONE.
REQ-016 The 17-bit accumulator SHALL never wrap (maximum 99999).
REQ-017 In DONE, SHALL drive done=1 and busy=0, update value/overflow/bad_char, and return to IDLE on the next edge.
REQ-018 DONE result selection SHALL take the first matching rule: bad flag set -> value=0, bad_char=1, overflow=0; acc > 65535 -> value=16'hFFFF, overflow=1; otherwise value=acc[15:0] with both flags 0.
REQ-019 done SHALL be high during the cycle after edge t+6 (start sampled at edge t), a latency of 6 cycles.
REQ-020 value, overflow and bad_char SHALL hold until the next DONE.
REQ-021 start SHALL be ignored while busy=1 or in DONE; no queuing.
REQ-022 The earliest following request SHALL be accepted at the first edge after done is high, giving a throughput of one conversion per 7 cycles.
REQ-023 Input characters SHALL be sampled only at the accepting edge; later input changes SHALL not affect the result.
REQ-024 All five characters being spaces (ALLOW_SPACE=1) SHALL yield value=0 with no flags.

Reset
REQ-025 rst_i=1 at an edge SHALL force IDLE and set busy=0, done=0, value=0, overflow=0, bad_char=0, and clear the accumulator, counter, shift register and bad flag.
REQ-026 Reset SHALL take priority over start and over any in-flight conversion, which is discarded without a done pulse.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding, ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, NUM_DIGITS=5 and MAX_VALUE=65535.
REQ-028 One sub-module, from_dec_char, SHALL classify a character (digit/space/illegal) and return its 4-bit digit value combinationally.
REQ-029 Everything else SHALL be in a single sequential process.

Verification
REQ-030 Bench SHALL drive "65535" + start -> after 6 cycles done=1, value=16'hFFFF, overflow=0, bad_char=0.
REQ-031 Bench SHALL drive "65536" -> value=16'hFFFF, overflow=1; and "99999" -> the same result.
REQ-032 Bench SHALL drive "  042" with ALLOW_SPACE=1 -> value=42; drive "4 2  " -> bad_char=1, value=0; drive "12a45" -> bad_char=1, value=0.
REQ-033 Bench SHALL drive "00000" -> value=0, and "01234" -> value=1234, with start held high for 10 cycles -> exactly one done per 7 cycles and each input sampled only at acceptance.
REQ-034 Bench SHALL assert rst_i during the 3rd ACCUM cycle of "54321" -> no done pulse, all outputs 0; a fresh "00007" -> value=7.
REQ-035 Bench SHALL pulse start while busy -> ignored, with the first result unchanged.
